instr_prefetch_buffer: RTL and testbench

- IF-stage block directly upstream of the ID-stage decoder; supplies its 32-bit instruction word, plus the matching PC and a valid flag.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and buffers in-order responses in a small FIFO.
- Flushes the FIFO and in-flight fetches on a redirect from branch, JAL/JALR or trap resolution.
- Presents a NOP (addi x0,x0,0 = 32'h00000013) whenever no valid instruction is available, so the decoder sees no write-back.

---
 rtl/instr_prefetch_buffer.sv | 99 +++++++++
 tb/tb_instr_prefetch_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: IF-stage sequential prefetcher with an in-order response FIFO and redirect flush.
// Optional feature macro PREFETCH_BYPASS_EN: a live response into an empty FIFO drives the outputs in the same cycle.
module instr_prefetch_buffer #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count, outstanding, drop_cnt, os_sum, os_next;
    logic [CW:0]   credit_used;
    logic [31:0]   fetch_pc, rsp_pc, target;
    logic          req_fire, rsp_seen, rsp_live, bypass, push, pop, fifo_empty;

    // Credit-based request issue, response classification and FIFO push/pop decisions
    always_comb begin
        fifo_empty       = fifo_count == '0;
        credit_used      = {1'b0, fifo_count} + {1'b0, outstanding - drop_cnt};
        imem_req_valid_o = resetn && outstanding < CW'(MAX_OUTSTANDING) && credit_used < (CW+1)'(DEPTH);
        imem_req_addr_o  = fetch_pc;
        req_fire         = imem_req_valid_o && imem_req_ready_i;
        rsp_seen         = resetn && imem_rsp_valid_i;
        os_sum           = outstanding + CW'(req_fire);
        os_next          = (rsp_seen && os_sum != '0) ? os_sum - CW'(1) : os_sum;
        rsp_live         = rsp_seen && drop_cnt == '0 && !redirect_i;
`ifdef PREFETCH_BYPASS_EN
        bypass           = rsp_live && fifo_empty;
`else
        bypass           = 1'b0;
`endif
        push             = rsp_live && !(bypass && id_ready_i);
        pop              = !redirect_i && !fifo_empty && id_ready_i;
        target           = redirect_pc_i & ~32'h3;
    end

    // Decoder-facing view: FIFO head, bypassed response, or NOP when nothing valid
    always_comb begin
        instr_valid_o = resetn && (!fifo_empty || bypass);
        instr_o       = !instr_valid_o ? NOP : bypass ? imem_rsp_data_i : fifo_data[rd_ptr];
        pc_o          = !instr_valid_o ? 32'h0 : bypass ? rsp_pc : fifo_pc[rd_ptr];
    end

    // Control state: fetch/response PCs, pointers, occupancy and stale-response accounting
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= os_next;
            if (redirect_i) begin
                fetch_pc   <= target;
                rsp_pc     <= target;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
                drop_cnt   <= os_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_live) rsp_pc <= rsp_pc + 32'd4;
                if (rsp_seen && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Entry storage; needs no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data_i;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed bench with an in-order memory model and a sequential-stream reference.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT1 = 1;
`else
    localparam int LAT1 = 2;
`endif

    logic        clk = 0, resetn = 0, imem_req_ready_i = 1, imem_rsp_valid_i = 0;
    logic        redirect_i = 0, id_ready_i = 0;
    logic        imem_req_valid_o, instr_valid_o;
    logic [31:0] imem_req_addr_o, instr_o, pc_o;
    logic [31:0] imem_rsp_data_i = 0, redirect_pc_i = 0;

    int          total = 0, bad = 0, ecount = 0, lat = 1, last_due = 0, due = 0;
    int          first_fire = -1, first_valid = -1;
    logic        checking = 0, found = 0;
    logic [31:0] exp_pc = 0, exp_fetch = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .id_ready_i(id_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    // Reference: the decoder must see the architectural stream exp_pc, exp_pc+4, ... with mem() data
    always @(negedge clk) if (checking) begin
        if (!resetn) begin
            chk1("rst_valid", instr_valid_o, 1'b0);
            chk("rst_instr", instr_o, NOP);
            chk("rst_pc", pc_o, 32'h0);
            chk1("rst_req", imem_req_valid_o, 1'b0);
            exp_pc = 0;
            exp_fetch = 0;
        end else begin
            if (instr_valid_o) begin
                chk("out_pc", pc_o, exp_pc);
                chk("out_instr", instr_o, mem(exp_pc));
                if (first_valid < 0) first_valid = ecount;
            end else begin
                chk("idle_instr", instr_o, NOP);
                chk("idle_pc", pc_o, 32'h0);
            end
            chk1("credit", (exp_fetch - exp_pc) <= 32'(4 * DEPTH), 1'b1);
            if (imem_req_valid_o) chk("req_addr", imem_req_addr_o, exp_fetch);
            if (imem_req_valid_o && imem_req_ready_i) begin
                chk1("outstanding", (q_addr.size() + int'(imem_rsp_valid_i)) < MAXO, 1'b1);
                if (first_fire < 0) first_fire = ecount;
                due = ecount + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                q_addr.push_back(imem_req_addr_o);
                q_due.push_back(due);
                exp_fetch += 4;
            end
            if (instr_valid_o && id_ready_i) exp_pc += 4;
            if (redirect_i) begin
                exp_pc = redirect_pc_i & ~32'h3;
                exp_fetch = redirect_pc_i & ~32'h3;
            end
        end
    end

    // In-order memory: each accepted request answered exactly lat cycles later (order preserved)
    initial forever begin
        @(posedge clk);
        #1;
        if (q_due.size() != 0 && q_due[0] == ecount) begin
            imem_rsp_valid_i = 1;
            imem_rsp_data_i = mem(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid_i = 0;
            imem_rsp_data_i = 32'hDEAD_BEEF;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instr_valid_o) break;
        end
        if (i == budget) begin
            total++;
            bad++;
            $display("FAIL %s: instr_valid_o got 0 for %0d cycles want 1", name, budget);
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_i = 1;
        redirect_pc_i = t;
        cyc(1);
        redirect_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_ready_i = 1;
        cyc(1);
        checking = 1;
        cyc(2);
        // free-running stream, 1-cycle memory
        resetn = 1;
        cyc(12);
        @(negedge clk);
        chk("t1_latency", 32'(first_valid - first_fire), 32'(LAT1));
        chk("t1_first_fire", 32'(first_fire), 32'(first_fire >= 0 ? first_fire : -2));
        chk("t1_stream_pc", pc_o, 32'(4 * (14 - LAT1) - 8));
        // decoder stalled: FIFO fills, head held, requests stop
        @(posedge clk);
        #1;
        resetn = 0;
        cyc(3);
        id_ready_i = 0;
        resetn = 1;
        cyc(10);
        @(negedge clk);
        chk1("t2_req_stop", imem_req_valid_o, 1'b0);
        chk1("t2_valid", instr_valid_o, 1'b1);
        chk("t2_hold_pc", pc_o, 32'h0);
        chk("t2_hold_instr", instr_o, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        id_ready_i = 1;
        cyc(10);
        // redirect with two stale fetches in flight, 3-cycle memory
        lat = 3;
        found = 0;
        repeat (30) begin
            @(posedge clk);
            #2;
            if (q_addr.size() + int'(imem_rsp_valid_i) == 2 && !imem_rsp_valid_i) begin
                found = 1;
                break;
            end
        end
        chk1("t3_two_outstanding", found, 1'b1);
        do_redirect(32'h100);
        wait_valid("t3_wait", 30);
        chk("t3_pc", pc_o, 32'h100);
        chk("t3_instr", instr_o, 32'h3CD4_410D);
        @(posedge clk);
        #1;
        // redirect coinciding with a response and a request fire
        lat = 1;
        cyc(8);
        found = 0;
        repeat (30) begin
            @(posedge clk);
            #2;
            if (imem_req_valid_o && imem_req_ready_i && imem_rsp_valid_i) begin
                found = 1;
                break;
            end
        end
        chk1("t4_coincide", found, 1'b1);
        do_redirect(32'h200);
        wait_valid("t4_wait", 30);
        chk("t4_pc", pc_o, 32'h200);
        @(posedge clk);
        #1;
        // reset mid-stream with responses in flight
        lat = 3;
        cyc(7);
        resetn = 0;
        @(negedge clk);
        chk1("t5_rst_valid", instr_valid_o, 1'b0);
        chk("t5_rst_instr", instr_o, NOP);
        @(posedge clk);
        #1;
        cyc(6);
        resetn = 1;
        wait_valid("t5_wait", 30);
        chk("t5_pc", pc_o, 32'h0);
        @(posedge clk);
        #1;
        // address wrap and unaligned target
        lat = 1;
        cyc(5);
        do_redirect(32'hFFFF_FFFC);
        wait_valid("t6_wait_a", 30);
        chk("t6_pc_top", pc_o, 32'hFFFF_FFFC);
        wait_valid("t6_wait_b", 30);
        chk("t6_pc_wrap", pc_o, 32'h0);
        @(posedge clk);
        #1;
        do_redirect(32'h102);
        wait_valid("t6_wait_c", 30);
        chk("t6_pc_align", pc_o, 32'h100);
        @(posedge clk);
        #1;
        // irregular memory and decoder handshakes
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            imem_req_ready_i = (i % 3) != 0;
            id_ready_i = (i % 4) != 1;
            cyc(1);
        end
        imem_req_ready_i = 1;
        id_ready_i = 1;
        cyc(12);
        @(negedge clk);
        chk1("t7_flowing", instr_valid_o, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
